// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, reads imem over req/ack and feeds the
// IF/ID register, with a one-word skid buffer and beq/j redirect handling.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        nPC_sel,
    input  logic        zero,
    input  logic        j_sel,
    input  logic [31:0] br_pc4,
    input  logic [15:0] br_imm16,
    input  logic [25:0] j_tgt26,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic [5:0]  id_type,
    output logic [5:0]  id_lsbs
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DROP,
        S_HOLD
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_old_addr;
    logic [31:0] w_old_addr_nxt;
    logic [31:0] r_skid;
    logic [31:0] w_skid_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic [31:0] r_instr;
    logic [31:0] w_instr_nxt;
    logic [31:0] r_pc4;
    logic [31:0] w_pc4_nxt;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_inc;
    logic        w_load;
    logic [31:0] w_load_instr;
    logic [31:0] w_load_pc4;

    assign w_redirect = (nPC_sel & zero) | j_sel;
    assign w_target   = j_sel ? {br_pc4[31:28], j_tgt26, 2'b00}
                              : br_pc4 + {{14{br_imm16[15]}}, br_imm16, 2'b00};
    assign w_pc_inc   = r_pc + 32'd4;

    // The skid word's PC+4 equals the already-advanced PC while in HOLD.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_old_addr_nxt = r_old_addr;
        w_skid_nxt     = r_skid;
        w_load         = 1'b0;
        w_load_instr   = imem_rdata;
        w_load_pc4     = w_pc_inc;
        unique case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
                if (w_redirect) w_pc_nxt = w_target;
            end
            S_FETCH: begin
                if (w_redirect) begin
                    w_pc_nxt = w_target;
                    if (!imem_ack) begin
                        w_old_addr_nxt = r_pc;
                        w_state_nxt    = S_DROP;
                    end
                end else if (imem_ack) begin
                    w_pc_nxt = w_pc_inc;
                    if (r_valid && stall) begin
                        w_skid_nxt  = imem_rdata;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            S_DROP: begin
                if (w_redirect) w_pc_nxt = w_target;
                if (imem_ack) w_state_nxt = S_FETCH;
            end
            S_HOLD: begin
                if (w_redirect) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = S_FETCH;
                end else if (!stall) begin
                    w_load       = 1'b1;
                    w_load_instr = r_skid;
                    w_load_pc4   = r_pc;
                    w_state_nxt  = S_FETCH;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_valid_nxt = r_valid;
        w_instr_nxt = r_instr;
        w_pc4_nxt   = r_pc4;
        if (w_redirect) begin
            w_valid_nxt = 1'b0;
        end else if (stall && r_valid) begin
            w_valid_nxt = 1'b1;
        end else if (w_load) begin
            w_valid_nxt = 1'b1;
            w_instr_nxt = w_load_instr;
            w_pc4_nxt   = w_load_pc4;
        end else begin
            w_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_old_addr <= RESET_PC;
            r_skid     <= 32'd0;
            r_valid    <= 1'b0;
            r_instr    <= 32'd0;
            r_pc4      <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_old_addr <= w_old_addr_nxt;
            r_skid     <= w_skid_nxt;
            r_valid    <= w_valid_nxt;
            r_instr    <= w_instr_nxt;
            r_pc4      <= w_pc4_nxt;
        end
    end

    assign imem_req  = (r_state == S_FETCH) || (r_state == S_DROP);
    assign imem_addr = (r_state == S_DROP) ? r_old_addr : r_pc;
    assign id_valid  = r_valid;
    assign id_instr  = r_instr;
    assign id_pc4    = r_pc4;
    assign id_type   = r_instr[31:26];
    assign id_lsbs   = r_instr[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a queue-based fetch model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        nPC_sel;
    logic        zero;
    logic        j_sel;
    logic [31:0] br_pc4;
    logic [15:0] br_imm16;
    logic [25:0] j_tgt26;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic [5:0]  id_type;
    logic [5:0]  id_lsbs;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .stall     (stall),
        .nPC_sel   (nPC_sel),
        .zero      (zero),
        .j_sel     (j_sel),
        .br_pc4    (br_pc4),
        .br_imm16  (br_imm16),
        .j_tgt26   (j_tgt26),
        .id_valid  (id_valid),
        .id_instr  (id_instr),
        .id_pc4    (id_pc4),
        .id_type   (id_type),
        .id_lsbs   (id_lsbs)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] want);
        n_total++;
        if (obs === want) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h want %h at %0t", tag, obs, want, $time);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    // Model: fetch started flag, next PC, an outstanding stale read,
    // a queue of words fetched but not yet handed to decode, and IF/ID.
    bit          m_started;
    logic [31:0] m_pc;
    bit          m_stale;
    logic [31:0] m_stale_addr;
    logic [63:0] m_skid[$];
    bit          m_v;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;

    bit          d_on = 0;
    logic        d_npc, d_zero, d_j;
    logic [31:0] d_pc4;
    logic [15:0] d_imm;
    logic [25:0] d_tgt;

    task automatic model_reset;
        m_started    = 0;
        m_pc         = RESET_PC;
        m_stale      = 0;
        m_stale_addr = 32'd0;
        m_skid.delete();
        m_v          = 0;
        m_instr      = 32'd0;
        m_pc4        = 32'd0;
    endtask

    function automatic bit m_req();
        return m_started && (m_skid.size() == 0);
    endfunction

    task automatic idle_in;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        stall      = 1'b0;
        nPC_sel    = 1'b0;
        zero       = 1'b0;
        j_sel      = 1'b0;
        br_pc4     = 32'd0;
        br_imm16   = 16'd0;
        j_tgt26    = 26'd0;
    endtask

    task automatic model_update;
        bit          rd;
        bit          acc;
        bit          was_stale;
        bit          v_old;
        logic [31:0] tg;
        rd = (nPC_sel && zero) || j_sel;
        if (j_sel)
            tg = {br_pc4[31:28], j_tgt26, 2'b00};
        else
            tg = br_pc4 + 32'($signed(br_imm16)) * 32'd4;
        acc       = m_req() && imem_ack;
        was_stale = m_stale;
        v_old     = m_v;
        if (!m_started) begin
            m_started = 1;
            if (rd) m_pc = tg;
            m_v = 0;
            return;
        end
        if (rd) begin
            m_v = 0;
        end else if (stall && v_old) begin
            if (acc && !was_stale) m_skid.push_back({word(m_pc), m_pc + 32'd4});
        end else if (m_skid.size() != 0) begin
            {m_instr, m_pc4} = m_skid.pop_front();
            m_v = 1;
        end else if (acc && !was_stale) begin
            m_instr = word(m_pc);
            m_pc4   = m_pc + 32'd4;
            m_v     = 1;
        end else begin
            m_v = 0;
        end
        if (rd) begin
            if (m_req() && !imem_ack && !was_stale) begin
                m_stale      = 1;
                m_stale_addr = m_pc;
            end
            m_skid.delete();
            m_pc = tg;
        end else if (acc && !was_stale) begin
            m_pc = m_pc + 32'd4;
        end
        if (acc && was_stale) m_stale = 0;
    endtask

    task automatic compare_model;
        check("req", {31'd0, imem_req}, {31'd0, m_req()});
        if (m_req())
            check("addr", imem_addr, m_stale ? m_stale_addr : m_pc);
        check("valid", {31'd0, id_valid}, {31'd0, m_v});
        if (m_v) begin
            check("instr", id_instr, m_instr);
            check("pc4", id_pc4, m_pc4);
            check("type", {26'd0, id_type}, {26'd0, m_instr[31:26]});
            check("lsbs", {26'd0, id_lsbs}, {26'd0, m_instr[5:0]});
        end
    endtask

    task automatic drive(input int ack_pct, input int stall_pct, input int redir_pct);
        imem_ack   = m_req() && ($urandom_range(99) < ack_pct);
        imem_rdata = imem_ack ? word(imem_addr) : $urandom;
        stall      = $urandom_range(99) < stall_pct;
        br_pc4     = 32'h3000 + 32'($urandom_range(63)) * 32'd4;
        br_imm16   = 16'($urandom_range(31)) - 16'd16;
        j_tgt26    = 26'h0000C00 + 26'($urandom_range(63));
        nPC_sel    = 1'($urandom_range(1));
        zero       = 1'b0;
        j_sel      = 1'b0;
        if (d_on) begin
            nPC_sel  = d_npc;
            zero     = d_zero;
            j_sel    = d_j;
            br_pc4   = d_pc4;
            br_imm16 = d_imm;
            j_tgt26  = d_tgt;
        end else if ($urandom_range(99) < redir_pct) begin
            zero  = 1'($urandom_range(1));
            j_sel = 1'($urandom_range(1));
        end
    endtask

    task automatic step(input int ack_pct, input int stall_pct, input int redir_pct);
        compare_model();
        drive(ack_pct, stall_pct, redir_pct);
        model_update();
    endtask

    task automatic tick(input int n, input int ack_pct, input int stall_pct,
                        input int redir_pct);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            step(ack_pct, stall_pct, redir_pct);
        end
    endtask

    task automatic set_dir(input logic npc, input logic z, input logic j,
                           input logic [31:0] pc4, input logic [15:0] imm,
                           input logic [25:0] tgt);
        d_on   = 1;
        d_npc  = npc;
        d_zero = z;
        d_j    = j;
        d_pc4  = pc4;
        d_imm  = imm;
        d_tgt  = tgt;
    endtask

    task automatic reset_checks;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", {31'd0, id_valid}, 32'd0);
        check("rst_instr", id_instr, 32'd0);
        check("rst_pc4", id_pc4, 32'd0);
        check("rst_type", {26'd0, id_type}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_in();
        model_reset();
        @(negedge clk);
        reset_checks();
        rst_n = 1'b1;
        model_update();

        // Back-to-back zero-latency fetch
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("seq_addr", imem_addr, RESET_PC + 32'(i) * 32'd4);
            if (i > 0) check("seq_pc4", id_pc4, RESET_PC + 32'(i) * 32'd4);
            step(100, 0, 0);
        end
        tick(8, 100, 0, 0);

        // Stall held while a fetch acks
        tick(1, 100, 100, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("hold_req", {31'd0, imem_req}, 32'd0);
            step(100, 100, 0);
        end
        tick(4, 100, 0, 0);

        // beq taken backwards
        set_dir(1'b1, 1'b1, 1'b0, 32'h3010, 16'hFFFE, 26'd0);
        tick(1, 100, 0, 0);
        d_on = 0;
        @(negedge clk);
        check("beq_addr", imem_addr, 32'h3008);
        check("beq_flush", {31'd0, id_valid}, 32'd0);
        step(100, 0, 0);
        set_dir(1'b1, 1'b0, 1'b0, 32'h3010, 16'hFFFE, 26'd0);
        tick(1, 100, 0, 0);
        d_on = 0;
        tick(2, 100, 0, 0);

        // Jump beats a taken beq
        set_dir(1'b1, 1'b1, 1'b1, 32'h3010, 16'h0040, 26'h0000C04);
        tick(1, 100, 0, 0);
        d_on = 0;
        @(negedge clk);
        check("j_addr", imem_addr, 32'h3010);
        step(100, 0, 0);
        tick(2, 100, 0, 0);

        // Redirect with the read still pending
        set_dir(1'b1, 1'b1, 1'b0, 32'h3100, 16'h0000, 26'd0);
        tick(1, 0, 0, 0);
        d_on = 0;
        tick(2, 0, 0, 0);
        tick(1, 100, 0, 0);
        @(negedge clk);
        check("drop_addr", imem_addr, 32'h3100);
        step(100, 0, 0);
        tick(2, 100, 0, 0);

        // PC wrap at the top of the address space
        set_dir(1'b0, 1'b0, 1'b1, 32'hF000_0000, 16'd0, 26'h3FF_FFFE);
        tick(1, 100, 0, 0);
        d_on = 0;
        tick(2, 100, 0, 0);
        @(negedge clk);
        check("wrap_addr", imem_addr, 32'd0);
        step(100, 0, 0);
        tick(3, 100, 0, 0);

        tick(300, 60, 40, 0);
        tick(600, 50, 30, 10);
        tick(400, 25, 20, 15);

        // Reset asserted with a request outstanding and stall high
        tick(3, 100, 0, 0);
        tick(2, 0, 100, 0);
        @(negedge clk);
        check("pre_rst_req", {31'd0, imem_req}, 32'd1);
        rst_n = 1'b0;
        stall = 1'b1;
        #1;
        reset_checks();
        model_reset();
        @(negedge clk);
        compare_model();
        idle_in();
        rst_n = 1'b1;
        model_update();
        @(negedge clk);
        check("restart_addr", imem_addr, RESET_PC);
        step(100, 0, 0);
        tick(400, 50, 30, 10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
